// File: rtl/uart_alu_sequencer_pkg.sv
// Shared definitions for the UART/ALU command sequencer and its wrapper.
// Holds the data width and timeout defaults, plus the state encoding that
// is exported on the debug state port.
package uart_alu_sequencer_pkg;

  localparam int unsigned DBIT_DEF          = 8;
  localparam int unsigned TIMEOUT_TICKS_DEF = 2048;
  localparam int unsigned TW_DEF            = 12;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GET_B   = 3'd1,
    ST_GET_OP  = 3'd2,
    ST_EXEC    = 3'd3,
    ST_SEND    = 3'd4,
    ST_WAIT_TX = 3'd5
  } state_t;

  // True while a partial command is being collected (timeout is armed).
  function automatic logic collecting(input state_t s);
    return (s == ST_GET_B) || (s == ST_GET_OP);
  endfunction

endpackage

// File: rtl/uart_alu_sequencer_tick_timer.sv
// Inter-byte timeout timer counting s_tick pulses.
// Ports: clk, reset (async active-low), clear (sync clear, has priority),
//        enable (count allowed), s_tick (count pulse), terminal_c (count has
//        reached TIMEOUT_TICKS; combinational decode of the counter register).
module uart_alu_sequencer_tick_timer
  import uart_alu_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int unsigned TW            = TW_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  input  logic s_tick,
  output logic terminal_c
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_TICKS);

  logic [TW-1:0] cnt;

  // Saturating counter: holds at LIMIT instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && s_tick && (cnt != LIMIT)) begin
      cnt <= cnt + TW'(1);
    end
  end

  assign terminal_c = (cnt == LIMIT);

endmodule

// File: rtl/uart_alu_sequencer.sv
// Command sequencer between the UART receiver and the ALU/transmitter.
// Collects operand A, operand B and opcode bytes, executes on the ALU,
// launches the result to the transmitter and waits for completion.
// Ports: clk, reset (async active-low); s_tick, rx_data, rx_done_tick from
//        the receiver side; alu_result from the ALU; tx_done_tick from the
//        transmitter. Registered outputs: alu_a, alu_b, alu_op, tx_data,
//        tx_start, busy, timeout_err, overrun_err, state (debug).
module uart_alu_sequencer
  import uart_alu_sequencer_pkg::*;
#(
  parameter int unsigned DBIT          = DBIT_DEF,
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_DEF,
  parameter int unsigned TW            = TW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic [DBIT-1:0] rx_data,
  input  logic            rx_done_tick,
  input  logic [DBIT-1:0] alu_result,
  input  logic            tx_done_tick,
  output logic [DBIT-1:0] alu_a,
  output logic [DBIT-1:0] alu_b,
  output logic [DBIT-1:0] alu_op,
  output logic [DBIT-1:0] tx_data,
  output logic            tx_start,
  output logic            busy,
  output logic            timeout_err,
  output logic            overrun_err,
  output logic [2:0]      state
);

  state_t state_q;
  state_t state_nxt;

  logic [DBIT-1:0] alu_a_d;
  logic [DBIT-1:0] alu_b_d;
  logic [DBIT-1:0] alu_op_d;
  logic [DBIT-1:0] tx_data_d;
  logic            tx_start_d;
  logic            timeout_d;
  logic            overrun_d;
  logic            timer_clear;
  logic            timer_en;
  logic            terminal_c;

  // Cleared outside collection and on every accepted byte, which also
  // covers entry into GET_B / GET_OP.
  assign timer_en    = collecting(state_q);
  assign timer_clear = rx_done_tick || !timer_en;

  uart_alu_sequencer_tick_timer #(
    .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .TW           (TW)
  ) u_tick_timer (
    .clk       (clk),
    .reset     (reset),
    .clear     (timer_clear),
    .enable    (timer_en),
    .s_tick    (s_tick),
    .terminal_c(terminal_c)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic; a received byte wins over a coincident timeout.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:    if (rx_done_tick) state_nxt = ST_GET_B;
      ST_GET_B: begin
        if (rx_done_tick)    state_nxt = ST_GET_OP;
        else if (terminal_c) state_nxt = ST_IDLE;
      end
      ST_GET_OP: begin
        if (rx_done_tick)    state_nxt = ST_EXEC;
        else if (terminal_c) state_nxt = ST_IDLE;
      end
      ST_EXEC:    state_nxt = ST_SEND;
      ST_SEND:    state_nxt = ST_WAIT_TX;
      ST_WAIT_TX: if (tx_done_tick) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Output next-values; tx_start is set while in EXEC so its registered
  // pulse lines up with the SEND state.
  always_comb begin
    alu_a_d    = alu_a;
    alu_b_d    = alu_b;
    alu_op_d   = alu_op;
    tx_data_d  = tx_data;
    tx_start_d = 1'b0;
    timeout_d  = 1'b0;
    overrun_d  = 1'b0;
    case (state_q)
      ST_IDLE:    if (rx_done_tick) alu_a_d = rx_data;
      ST_GET_B: begin
        if (rx_done_tick)    alu_b_d   = rx_data;
        else if (terminal_c) timeout_d = 1'b1;
      end
      ST_GET_OP: begin
        if (rx_done_tick)    alu_op_d  = rx_data;
        else if (terminal_c) timeout_d = 1'b1;
      end
      ST_EXEC: begin
        tx_data_d  = alu_result;
        tx_start_d = 1'b1;
        overrun_d  = rx_done_tick;
      end
      ST_SEND:    overrun_d = rx_done_tick;
      ST_WAIT_TX: overrun_d = rx_done_tick;
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= '0;
      tx_data     <= '0;
      tx_start    <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      alu_a       <= alu_a_d;
      alu_b       <= alu_b_d;
      alu_op      <= alu_op_d;
      tx_data     <= tx_data_d;
      tx_start    <= tx_start_d;
      busy        <= (state_nxt != ST_IDLE);
      timeout_err <= timeout_d;
      overrun_err <= overrun_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
module tb_uart_alu_sequencer;

  localparam int unsigned DBIT = 8;
  localparam int unsigned T    = 64;
  localparam int unsigned TW   = 7;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GET_B   = 3'd1;
  localparam logic [2:0] S_GET_OP  = 3'd2;
  localparam logic [2:0] S_EXEC    = 3'd3;
  localparam logic [2:0] S_SEND    = 3'd4;
  localparam logic [2:0] S_WAIT_TX = 3'd5;

  logic            clk = 1'b0;
  logic            reset;
  logic            s_tick;
  logic [DBIT-1:0] rx_data;
  logic            rx_done_tick;
  logic [DBIT-1:0] alu_result;
  logic            tx_done_tick;
  logic [DBIT-1:0] alu_a;
  logic [DBIT-1:0] alu_b;
  logic [DBIT-1:0] alu_op;
  logic [DBIT-1:0] tx_data;
  logic            tx_start;
  logic            busy;
  logic            timeout_err;
  logic            overrun_err;
  logic [2:0]      state;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // ALU model: opcode low bits select add/sub/and/xor.
  function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] op);
    case (op[1:0])
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);

  uart_alu_sequencer #(
    .DBIT         (DBIT),
    .TIMEOUT_TICKS(T),
    .TW           (TW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_tick      (s_tick),
    .rx_data     (rx_data),
    .rx_done_tick(rx_done_tick),
    .alu_result  (alu_result),
    .tx_done_tick(tx_done_tick),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .tx_data     (tx_data),
    .tx_start    (tx_start),
    .busy        (busy),
    .timeout_err (timeout_err),
    .overrun_err (overrun_err),
    .state       (state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet();
    rx_done_tick = 1'b0;
    s_tick       = 1'b0;
    tx_done_tick = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    rx_data      = d;
    rx_done_tick = 1'b1;
    s_tick       = 1'b0;
    tx_done_tick = 1'b0;
    step();
    rx_done_tick = 1'b0;
    rx_data      = 8'($urandom);
  endtask

  // Idle cycles with random ticks (far fewer than T) and stray tx_done pulses.
  task automatic gap(input int n, input logic [2:0] exp_st);
    for (int i = 0; i < n; i++) begin
      s_tick       = 1'($urandom_range(0, 1));
      tx_done_tick = (exp_st != S_WAIT_TX) ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      chk("gap_state", 8'(state), 8'(exp_st));
      chk("gap_timeout", 8'(timeout_err), 8'd0);
    end
    quiet();
  endtask

  // Complete command; ends one cycle after tx_done_tick with state IDLE.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    logic [7:0] exp;
    exp = alu_fn(a, b, op);
    send_byte(a);
    chk("a_val", alu_a, a);
    chk("a_state", 8'(state), 8'(S_GET_B));
    chk("a_busy", 8'(busy), 8'd1);
    gap($urandom_range(0, 4), S_GET_B);
    send_byte(b);
    chk("b_val", alu_b, b);
    chk("b_state", 8'(state), 8'(S_GET_OP));
    gap($urandom_range(0, 4), S_GET_OP);
    send_byte(op);
    chk("op_val", alu_op, op);
    chk("exec_state", 8'(state), 8'(S_EXEC));
    chk("exec_txstart", 8'(tx_start), 8'd0);
    step();
    chk("send_state", 8'(state), 8'(S_SEND));
    chk("send_txstart", 8'(tx_start), 8'd1);
    chk("send_txdata", tx_data, exp);
    step();
    chk("wait_state", 8'(state), 8'(S_WAIT_TX));
    chk("wait_txstart", 8'(tx_start), 8'd0);
    gap($urandom_range(0, 4), S_WAIT_TX);
    chk("wait_txdata", tx_data, exp);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    chk("done_state", 8'(state), 8'(S_IDLE));
    chk("done_busy", 8'(busy), 8'd0);
    chk("done_overrun", 8'(overrun_err), 8'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, 8'(state), 8'(S_IDLE));
    chk({tag, "_alu_a"}, alu_a, 8'd0);
    chk({tag, "_alu_b"}, alu_b, 8'd0);
    chk({tag, "_alu_op"}, alu_op, 8'd0);
    chk({tag, "_tx_data"}, tx_data, 8'd0);
    chk({tag, "_tx_start"}, 8'(tx_start), 8'd0);
    chk({tag, "_busy"}, 8'(busy), 8'd0);
    chk({tag, "_timeout"}, 8'(timeout_err), 8'd0);
    chk({tag, "_overrun"}, 8'(overrun_err), 8'd0);
  endtask

  initial begin
    reset   = 1'b0;
    rx_data = 8'd0;
    quiet();
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;
    step();

    // Basic add command.
    run_cmd(8'h05, 8'h03, 8'h20);

    // Timeout after A and B, then restart with 0x44.
    send_byte(8'h11);
    send_byte(8'h22);
    s_tick = 1'b1;
    repeat (T) step();
    s_tick = 1'b0;
    chk("to_pre_state", 8'(state), 8'(S_GET_OP));
    chk("to_pre_flag", 8'(timeout_err), 8'd0);
    step();
    chk("to_state", 8'(state), 8'(S_IDLE));
    chk("to_flag", 8'(timeout_err), 8'd1);
    chk("to_busy", 8'(busy), 8'd0);
    chk("to_keep_a", alu_a, 8'h11);
    chk("to_keep_b", alu_b, 8'h22);
    step();
    chk("to_flag_end", 8'(timeout_err), 8'd0);
    send_byte(8'h44);
    chk("restart_a", alu_a, 8'h44);
    chk("restart_state", 8'(state), 8'(S_GET_B));

    // One tick short of the limit: no abort.
    s_tick = 1'b1;
    repeat (T - 1) step();
    s_tick = 1'b0;
    repeat (5) step();
    chk("short_state", 8'(state), 8'(S_GET_B));
    chk("short_flag", 8'(timeout_err), 8'd0);
    send_byte(8'h10);
    chk("short_b", alu_b, 8'h10);

    // Opcode arriving in the terminal-count cycle is accepted.
    s_tick = 1'b1;
    repeat (T) step();
    s_tick = 1'b0;
    send_byte(8'h01);
    chk("coin_state", 8'(state), 8'(S_EXEC));
    chk("coin_flag", 8'(timeout_err), 8'd0);
    step();
    chk("coin_send", 8'(tx_start), 8'd1);
    chk("coin_txdata", tx_data, 8'h34);
    chk("coin_flag2", 8'(timeout_err), 8'd0);
    step();
    chk("coin_wait", 8'(state), 8'(S_WAIT_TX));

    // Overrun while waiting on the transmitter.
    send_byte(8'h7F);
    chk("ovr_flag", 8'(overrun_err), 8'd1);
    chk("ovr_state", 8'(state), 8'(S_WAIT_TX));
    chk("ovr_txdata", tx_data, 8'h34);
    chk("ovr_alu_a", alu_a, 8'h44);
    step();
    chk("ovr_flag_end", 8'(overrun_err), 8'd0);
    tx_done_tick = 1'b1;
    step();
    tx_done_tick = 1'b0;
    chk("ovr_done", 8'(state), 8'(S_IDLE));

    // Asynchronous reset while in GET_OP.
    send_byte(8'hAA);
    send_byte(8'h55);
    chk("ar_pre", 8'(state), 8'(S_GET_OP));
    #3;
    reset = 1'b0;
    #1;
    chk_all_zero("async_reset");
    #2;
    reset = 1'b1;
    step();
    chk("ar_release", 8'(state), 8'(S_IDLE));
    run_cmd(8'h0F, 8'hF0, 8'h03);

    // Back-to-back commands followed by random ones.
    run_cmd(8'h81, 8'h7E, 8'h00);
    run_cmd(8'hC3, 8'h3C, 8'h02);
    for (int k = 0; k < 20; k++) begin
      run_cmd(8'($urandom), 8'($urandom), 8'($urandom));
      if ($urandom_range(0, 1) == 1) gap($urandom_range(1, 3), S_IDLE);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
